// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin write arbiter in front of one shared DATA_W-bit register.
//   Exactly one requester is granted per clock; its data is latched into the
//   register. The current owner may hold the register across consecutive
//   writes by asserting its lock bit together with its request.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   req       : per-requester write request (level)
//   lock      : per-requester lock, honoured only for the current owner
//   wdata     : packed write data, slice i = wdata[i*DATA_W +: DATA_W]
//   grant     : registered one-hot grant of the write just performed
//   out       : shared register contents
//   out_valid : high in the cycle after out was written
//   owner     : index of the last granted requester
//   collision_cnt : saturating count of edges with two or more requests
//                   (present only when SHARED_REG_COLLISION_CNT_EN is defined)
module shared_reg_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*DATA_W-1:0]    wdata,
  output logic [N_REQ-1:0]           grant,
  output logic [DATA_W-1:0]          out,
  output logic                       out_valid,
  output logic [$clog2(N_REQ)-1:0]   owner
`ifdef SHARED_REG_COLLISION_CNT_EN
  ,
  output logic [7:0]                 collision_cnt
`endif
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [N_REQ-1:0]    r_grant;
  logic [DATA_W-1:0]   r_out;
  logic                r_valid;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_ptr;

  logic                w_any;
  logic                w_lock_hit;
  logic [OW-1:0]       w_arb_idx;
  logic                w_do_grant;
  logic [OW-1:0]       w_win;
  logic [N_REQ-1:0]    w_onehot;

  assign w_any      = |req;
  assign w_lock_hit = req[r_owner] & lock[r_owner];

  // Round-robin search: first requester after ptr, wrapping modulo N_REQ.
  // Iterating from the farthest offset down lets the nearest one win.
  always_comb begin
    w_arb_idx = '0;
    for (int unsigned off = N_REQ; off >= 1; off--) begin
      int unsigned idx;
      idx = (int'(r_ptr) + off) % N_REQ;
      if (req[idx]) w_arb_idx = idx[OW-1:0];
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_do_grant   = 1'b0;
    w_win        = r_owner;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_do_grant   = 1'b1;
          w_win        = w_arb_idx;
          w_next_state = GRANTED;
        end
      end
      GRANTED, LOCKED: begin
        if (w_lock_hit) begin
          w_do_grant   = 1'b1;
          w_win        = r_owner;
          w_next_state = LOCKED;
        end else if (w_any) begin
          w_do_grant   = 1'b1;
          w_win        = w_arb_idx;
          w_next_state = GRANTED;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_onehot = N_REQ'(1) << w_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_owner <= '0;
      r_ptr   <= OW'(N_REQ - 1);
    end else begin
      r_state <= w_next_state;
      r_valid <= w_do_grant;
      r_grant <= w_do_grant ? w_onehot : '0;
      if (w_do_grant) begin
        r_out   <= wdata[int'(w_win)*DATA_W +: DATA_W];
        r_owner <= w_win;
        r_ptr   <= w_win;
      end
    end
  end

  assign grant     = r_grant;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign owner     = r_owner;

`ifdef SHARED_REG_COLLISION_CNT_EN
  logic [7:0] r_coll;
  logic       w_multi;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi = |(req & (req - N_REQ'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_coll <= '0;
    else if (w_multi && (r_coll != 8'hFF))
      r_coll <= r_coll + 8'd1;
  end

  assign collision_cnt = r_coll;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] lock;
  logic [7:0] wdata;
  logic [3:0] grant;
  logic [1:0] out;
  logic       out_valid;
  logic [1:0] owner;
`ifdef SHARED_REG_COLLISION_CNT_EN
  logic [7:0] collision_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [7:0] WD_IDX = 8'b11_10_01_00; // slice i = i

  shared_reg_arbiter #(.N_REQ(4), .DATA_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .wdata     (wdata),
    .grant     (grant),
    .out       (out),
    .out_valid (out_valid),
    .owner     (owner)
`ifdef SHARED_REG_COLLISION_CNT_EN
    ,
    .collision_cnt (collision_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = '0; wdata = WD_IDX;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; lock = '0; wdata = WD_IDX;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({grant, out, out_valid, owner} !== 9'b0) begin
        errors++;
        $display("FAIL reset[%0d]: grant=%b out=%0d valid=%b owner=%0d, want all 0",
                 i, grant, out, out_valid, owner);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || out !== 2'd0 || out_valid !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%b out=%0d valid=%b owner=%0d, want 0001 0 1 0",
               grant, out, out_valid, owner);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] eo [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (grant !== eg[i] || out !== eo[i] || out_valid !== 1'b1 || owner !== eo[i]) begin
        errors++;
        $display("FAIL fairness[%0d]: grant=%b out=%0d valid=%b owner=%0d, want %b %0d 1 %0d",
                 i, grant, out, out_valid, owner, eg[i], eo[i], eo[i]);
      end
    end
  endtask

  task automatic test_single_writer();
    do_reset();
    wdata = 8'b00_11_00_00;
    req = 4'b0100;
    tick();
    checks++;
    if (grant !== 4'b0100 || out !== 2'd3 || out_valid !== 1'b1 || owner !== 2'd2) begin
      errors++;
      $display("FAIL single_grant: grant=%b out=%0d valid=%b owner=%0d, want 0100 3 1 2",
               grant, out, out_valid, owner);
    end
    req = 4'b0000;
    wdata = WD_IDX;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || out !== 2'd3 || out_valid !== 1'b0 || owner !== 2'd2) begin
        errors++;
        $display("FAIL single_hold[%0d]: grant=%b out=%0d valid=%b owner=%0d, want 0000 3 0 2",
                 i, grant, out, out_valid, owner);
      end
    end
    // From IDLE with ptr=2 the next winner is 3.
    req = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b1000 || out !== 2'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_resume: grant=%b out=%0d valid=%b, want 1000 3 1",
               grant, out, out_valid);
    end
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL lock_pre: grant=%b, want 0010", grant);
    end
    // lock[3] from a non-owner is ignored while requester 1 holds the lock.
    lock = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || out !== 2'd1 || out_valid !== 1'b1 || owner !== 2'd1) begin
        errors++;
        $display("FAIL lock_hold[%0d]: grant=%b out=%0d valid=%b owner=%0d, want 0010 1 1 1",
                 i, grant, out, out_valid, owner);
      end
    end
    lock = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b0100 || out !== 2'd2 || owner !== 2'd2) begin
      errors++;
      $display("FAIL lock_release: grant=%b out=%0d owner=%0d, want 0100 2 2",
               grant, out, owner);
    end
    lock = 4'b0000;
    tick();
    checks++;
    if (grant !== 4'b1000 || out !== 2'd3) begin
      errors++;
      $display("FAIL lock_after: grant=%b out=%0d, want 1000 3", grant, out);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    req = 4'b1111;
    tick();
    tick();
    lock = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL midlock_locked: grant=%b owner=%0d, want 0010 1", grant, owner);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({grant, out, out_valid, owner} !== 9'b0) begin
      errors++;
      $display("FAIL midlock_reset: grant=%b out=%0d valid=%b owner=%0d, want all 0",
               grant, out, out_valid, owner);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || out !== 2'd0 || out_valid !== 1'b1 || owner !== 2'd0) begin
      errors++;
      $display("FAIL midlock_next: grant=%b out=%0d valid=%b owner=%0d, want 0001 0 1 0",
               grant, out, out_valid, owner);
    end
    lock = 4'b0000;
  endtask

`ifdef SHARED_REG_COLLISION_CNT_EN
  task automatic test_collision_cnt();
    do_reset();
    checks++;
    if (collision_cnt !== 8'd0) begin
      errors++;
      $display("FAIL coll_reset0: cnt=%0d, want 0", collision_cnt);
    end
    req = 4'b0011;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 100 || i == 255 || i == 300) begin
        checks++;
        if (collision_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
          errors++;
          $display("FAIL coll_count[%0d]: cnt=%0d, want %0d", i, collision_cnt,
                   (i > 255) ? 255 : i);
        end
      end
    end
    req = 4'b0001;
    tick();
    checks++;
    if (collision_cnt !== 8'd255) begin
      errors++;
      $display("FAIL coll_single: cnt=%0d, want 255", collision_cnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (collision_cnt !== 8'd0) begin
      errors++;
      $display("FAIL coll_clear: cnt=%0d, want 0", collision_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; wdata = WD_IDX;
    test_reset();
    test_fairness();
    test_single_writer();
    test_lock();
    test_reset_mid_lock();
`ifdef SHARED_REG_COLLISION_CNT_EN
    test_collision_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
